// File: rtl/imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter
//
// Shares one single-port, variable-latency memory between the fetch stage
// (read-only) and the data/MEM stage (read/write). A request seen in IDLE is
// latched into the memory-side registers. The memory handshake then runs until
// mem_ack arrives or the busy-cycle timeout expires. Completion (ack or err)
// is reported only to the stage that owns the memory.
//
// Arbitration: data wins a collision so that MEM-stage traffic drains first.
// After MAX_D_STREAK consecutive data grants taken while fetch was waiting,
// fetch is forced through so the front end cannot starve.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   if_req/if_addr       fetch read request (held until if_ack or if_err)
//   if_ack/if_rdata      fetch completion pulse and read data
//   if_err               fetch timeout pulse
//   if_stall             fetch must wait this cycle (if_req & ~if_ack)
//   d_req/d_we/d_addr/d_wdata  data request (held until d_ack or d_err)
//   d_ack/d_rdata        data completion pulse and read data
//   d_err                data timeout pulse
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ack    memory read data and one-cycle completion pulse
// -----------------------------------------------------------------------------
module imem_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int ADDR_W       = 30,
  parameter int MAX_D_STREAK = 3,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [WIDTH-1:0]  if_rdata,
  output logic              if_err,
  output logic              if_stall,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WIDTH-1:0]  d_wdata,
  output logic              d_ack,
  output logic [WIDTH-1:0]  d_rdata,
  output logic              d_err,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack
);

  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [SW-1:0]     streak_reg, streak_next;
  logic [TW-1:0]     tmo_reg, tmo_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [WIDTH-1:0]  mem_wdata_reg, mem_wdata_next;
  logic [WIDTH-1:0]  if_rdata_reg, if_rdata_next;
  logic [WIDTH-1:0]  d_rdata_reg, d_rdata_next;
  logic              fetch_forced;

  // Fetch has waited through the full data streak and must win this grant.
  assign fetch_forced = if_req && (streak_reg == STREAK_MAX);

  always_comb begin
    state_next     = state_reg;
    streak_next    = streak_reg;
    tmo_next       = tmo_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    if_ack         = 1'b0;
    d_ack          = 1'b0;
    if_err         = 1'b0;
    d_err          = 1'b0;

    case (state_reg)
      IDLE: begin
        // mem_ack here belongs to no one (e.g. a leftover after reset).
        if (d_req && !fetch_forced) begin
          state_next     = BUSY_D;
          tmo_next       = '0;
          mem_we_next    = d_we;
          mem_addr_next  = d_addr;
          mem_wdata_next = d_wdata;
          // Only grants that made fetch wait count toward its starvation.
          if (if_req && (streak_reg != STREAK_MAX)) begin
            streak_next = streak_reg + SW'(1);
          end
        end else if (if_req) begin
          state_next    = BUSY_IF;
          tmo_next      = '0;
          mem_we_next   = 1'b0;
          mem_addr_next = if_addr;
          streak_next   = '0;
        end
      end

      BUSY_IF: begin
        // An ack on the timeout cycle still completes the transaction.
        if (mem_ack) begin
          if_ack        = 1'b1;
          if_rdata_next = mem_rdata;
          state_next    = IDLE;
        end else if (tmo_reg == TMO_MAX) begin
          if_err     = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end

      BUSY_D: begin
        if (mem_ack) begin
          d_ack        = 1'b1;
          d_rdata_next = mem_rdata;
          state_next   = IDLE;
        end else if (tmo_reg == TMO_MAX) begin
          d_err      = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      streak_reg    <= '0;
      tmo_reg       <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      streak_reg    <= streak_next;
      tmo_reg       <= tmo_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_rdata_reg  <= if_rdata_next;
      d_rdata_reg   <= d_rdata_next;
    end
  end

  // mem_req comes straight from the state register, so it is glitch-free and
  // rises the cycle after the request is first seen.
  assign mem_req   = (state_reg != IDLE);
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  // Read data passes through on the ack cycle and is held afterwards.
  assign if_rdata = if_ack ? mem_rdata : if_rdata_reg;
  assign d_rdata  = d_ack  ? mem_rdata : d_rdata_reg;

  assign if_stall = if_req && !if_ack;

endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;

  localparam int WIDTH        = 32;
  localparam int ADDR_W       = 30;
  localparam int MAX_D_STREAK = 3;
  localparam int TIMEOUT      = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_ack;
  logic [WIDTH-1:0]  if_rdata;
  logic              if_err;
  logic              if_stall;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [WIDTH-1:0]  d_wdata = '0;
  logic              d_ack;
  logic [WIDTH-1:0]  d_rdata;
  logic              d_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata = '0;
  logic              mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  imem_port_arbiter #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .MAX_D_STREAK(MAX_D_STREAK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .if_err(if_err), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // Memory-side helper: waits (bounded) for mem_req, acks after lat cycles and
  // reports which port pulsed its ack: 1 = fetch, 2 = data, 0 = none, -1 = no request.
  task automatic serve(input int lat, output int who);
    bit seen;
    seen = 0;
    who = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1; break; end
    end
    if (seen) begin
      repeat (lat) @(negedge clk);
      mem_ack = 1; mem_rdata = $urandom;
      #1;
      who = if_ack ? 1 : (d_ack ? 2 : 0);
      @(negedge clk);
      mem_ack = 0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    if_req = 1; d_req = 1;
    @(negedge clk);
    #2 rst = 1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if ({if_ack, d_ack, if_err, d_err} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {if_ack, d_ack, if_err, d_err}); end
    checks++; if ({if_rdata, d_rdata} !== '0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, d_rdata); end
    apply_reset();
  endtask

  task automatic test_single_fetch();
    apply_reset();
    @(negedge clk);
    if_req = 1; if_addr = 30'h10;
    #1;
    checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0: got %0b want 1", if_stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_mem_req_c0: got %0b want 0", mem_req); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_mem_req_c1: got %0b want 1", mem_req); end
    checks++; if (mem_addr !== 30'h10) begin errors++; $display("FAIL fetch_mem_addr: got %h want 10", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem_we: got %0b want 0", mem_we); end
    @(negedge clk);
    checks++; if ({if_stall, if_ack} !== 2'b10) begin errors++; $display("FAIL fetch_c2: got stall,ack=%b want 10", {if_stall, if_ack}); end
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if ({if_ack, if_stall, d_ack} !== 3'b100) begin errors++; $display("FAIL fetch_c3: got ack,stall,d_ack=%b want 100", {if_ack, if_stall, d_ack}); end
    checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata: got %h want deadbeef", if_rdata); end
    @(negedge clk);
    mem_ack = 0; if_req = 0; mem_rdata = 32'h0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_idle: got mem_req %0b want 0", mem_req); end
    checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata_hold: got %h want deadbeef", if_rdata); end
  endtask

  task automatic test_data_write();
    apply_reset();
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 30'h20; d_wdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1;
    #1;
    checks++; if ({mem_req, mem_we} !== 2'b11) begin errors++; $display("FAIL wr_req_we: got %b want 11", {mem_req, mem_we}); end
    checks++; if (mem_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_wdata: got %h want 12345678", mem_wdata); end
    checks++; if (mem_addr !== 30'h20) begin errors++; $display("FAIL wr_addr: got %h want 20", mem_addr); end
    checks++; if ({d_ack, if_ack, d_err} !== 3'b100) begin errors++; $display("FAIL wr_ack: got d_ack,if_ack,d_err=%b want 100", {d_ack, if_ack, d_err}); end
    @(negedge clk);
    mem_ack = 0; d_req = 0; d_we = 0;
    #1;
    checks++; if ({mem_req, d_ack} !== 2'b00) begin errors++; $display("FAIL wr_idle: got mem_req,d_ack=%b want 00", {mem_req, d_ack}); end
  endtask

  task automatic test_contention();
    int who;
    int exp_seq[8] = '{2, 2, 2, 1, 2, 2, 2, 1};
    apply_reset();
    @(negedge clk);
    if_req = 1; if_addr = 30'h100; d_req = 1; d_we = 0; d_addr = 30'h200;
    for (int g = 0; g < 8; g++) begin
      serve(0, who);
      checks++;
      if (who !== exp_seq[g]) begin errors++; $display("FAIL contention_grant%0d: got owner %0d want %0d", g, who, exp_seq[g]); end
    end
    if_req = 0; d_req = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    apply_reset();
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 30'h44; if_req = 1; if_addr = 30'h55;
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({d_err, d_ack, if_err, if_ack} !== {(k == TIMEOUT + 1), 3'b000}) begin
        errors++; $display("FAIL timeout_busy%0d: got d_err,d_ack,if_err,if_ack=%b want %b", k, {d_err, d_ack, if_err, if_ack}, {(k == TIMEOUT + 1), 3'b000});
      end
    end
    d_req = 0;
    @(negedge clk);
    #1;
    checks++; if ({mem_req, d_err} !== 2'b00) begin errors++; $display("FAIL timeout_drop: got mem_req,d_err=%b want 00", {mem_req, d_err}); end
    @(negedge clk);
    checks++; if ({mem_req, mem_addr} !== {1'b1, 30'h55}) begin errors++; $display("FAIL timeout_if_grant: got req %0b addr %h want 1 55", mem_req, mem_addr); end
    mem_ack = 1;
    #1;
    checks++; if (if_ack !== 1'b1) begin errors++; $display("FAIL timeout_if_ack: got %0b want 1", if_ack); end
    @(negedge clk);
    mem_ack = 0; if_req = 0;
  endtask

  task automatic test_collision();
    apply_reset();
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 30'h7;
    repeat (TIMEOUT + 1) @(negedge clk);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    #1;
    checks++; if ({d_ack, d_err} !== 2'b10) begin errors++; $display("FAIL collision_ack: got d_ack,d_err=%b want 10", {d_ack, d_err}); end
    checks++; if (d_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL collision_rdata: got %h want cafef00d", d_rdata); end
    @(negedge clk);
    mem_ack = 0; d_req = 0;
    #1;
    checks++; if ({mem_req, d_err} !== 2'b00) begin errors++; $display("FAIL collision_idle: got mem_req,d_err=%b want 00", {mem_req, d_err}); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 30'h9; d_wdata = 32'h1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got mem_req %0b want 1", mem_req); end
    #2 rst = 1; mem_ack = 1;
    #1;
    checks++; if ({mem_req, mem_we, d_ack, if_ack, d_err, if_err} !== 6'b0) begin errors++; $display("FAIL rstmid_async: got %b want 000000", {mem_req, mem_we, d_ack, if_ack, d_err, if_err}); end
    @(negedge clk);
    rst = 0; d_req = 0; mem_ack = 0;
    @(negedge clk);
    mem_ack = 1;
    #1;
    checks++; if ({d_ack, if_ack, mem_req} !== 3'b000) begin errors++; $display("FAIL rstmid_late_ack: got d_ack,if_ack,mem_req=%b want 000", {d_ack, if_ack, mem_req}); end
    @(negedge clk);
    mem_ack = 0; if_req = 1; if_addr = 30'h33;
    @(negedge clk);
    checks++; if ({mem_req, mem_addr} !== {1'b1, 30'h33}) begin errors++; $display("FAIL rstmid_if_grant: got req %0b addr %h want 1 33", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
    #1;
    checks++; if ({if_ack, if_rdata} !== {1'b1, 32'hA5A5A5A5}) begin errors++; $display("FAIL rstmid_if_ack: got ack %0b data %h want 1 a5a5a5a5", if_ack, if_rdata); end
    @(negedge clk);
    mem_ack = 0; if_req = 0;
  endtask

  // Randomized traffic against a transaction-level model: each grant is decided
  // from the pending requests and the count of data grants fetch has sat through;
  // each transaction ends with an ack after a random latency, or an err once
  // TIMEOUT busy cycles have passed without one.
  task automatic test_random(input int n);
    bit ip, dp, win_d, dwe, early, ackb, errb;
    int streak, lat;
    logic [ADDR_W-1:0] ia, da;
    logic [WIDTH-1:0] wd, rd, last_i, last_d;
    logic [3:0] exp_pulse;
    apply_reset();
    ip = 0; dp = 0; dwe = 0; streak = 0; last_i = '0; last_d = '0;
    ia = '0; da = '0; wd = '0;
    @(negedge clk);
    for (int t = 0; t < n; t++) begin
      do begin
        if (!ip && $urandom_range(0, 1) == 1) begin
          ip = 1; ia = ADDR_W'($urandom); if_addr = ia;
        end
        if (!dp && $urandom_range(0, 1) == 1) begin
          dp = 1; da = ADDR_W'($urandom); dwe = 1'($urandom_range(0, 1)); wd = $urandom;
          d_addr = da; d_we = dwe; d_wdata = wd;
        end
      end while (!ip && !dp);
      if_req = ip; d_req = dp;
      mem_ack = ($urandom_range(0, 3) == 0); mem_rdata = $urandom;
      #1;
      checks++; if ({if_ack, if_err, d_ack, d_err, mem_req} !== 5'b0) begin errors++; $display("FAIL rand%0d_idle: got if_ack,if_err,d_ack,d_err,mem_req=%b want 00000", t, {if_ack, if_err, d_ack, d_err, mem_req}); end
      checks++; if (if_stall !== ip) begin errors++; $display("FAIL rand%0d_idle_stall: got %0b want %0b", t, if_stall, ip); end
      checks++; if ({if_rdata, d_rdata} !== {last_i, last_d}) begin errors++; $display("FAIL rand%0d_rdata_hold: got %h/%h want %h/%h", t, if_rdata, d_rdata, last_i, last_d); end

      win_d = dp && !(ip && streak == MAX_D_STREAK);
      if (win_d) begin
        if (ip && streak < MAX_D_STREAK) streak++;
      end else begin
        streak = 0;
      end
      lat = $urandom_range(0, TIMEOUT + 2);
      early = ($urandom_range(0, 3) == 0);

      for (int k = 0; k <= TIMEOUT; k++) begin
        @(negedge clk);
        rd = $urandom; mem_rdata = rd; mem_ack = (k == lat);
        if (k == 0 && early) begin
          if (win_d) begin dp = 0; d_req = 0; end else begin ip = 0; if_req = 0; end
        end
        #1;
        if (k == 0) begin
          checks++;
          if ({mem_req, mem_we, mem_addr} !== {1'b1, win_d && dwe, win_d ? da : ia}) begin
            errors++; $display("FAIL rand%0d_grant: got req %0b we %0b addr %h want 1 %0b %h", t, mem_req, mem_we, mem_addr, win_d && dwe, win_d ? da : ia);
          end
          if (win_d && dwe) begin
            checks++; if (mem_wdata !== wd) begin errors++; $display("FAIL rand%0d_wdata: got %h want %h", t, mem_wdata, wd); end
          end
        end
        ackb = (k == lat);
        errb = (k == TIMEOUT) && (lat > TIMEOUT);
        exp_pulse = win_d ? {2'b00, ackb, errb} : {ackb, errb, 2'b00};
        checks++;
        if ({if_ack, if_err, d_ack, d_err} !== exp_pulse) begin
          errors++; $display("FAIL rand%0d_pulse_k%0d: got if_ack,if_err,d_ack,d_err=%b want %b", t, k, {if_ack, if_err, d_ack, d_err}, exp_pulse);
        end
        checks++; if (if_stall !== (ip && !(ackb && !win_d))) begin errors++; $display("FAIL rand%0d_stall_k%0d: got %0b want %0b", t, k, if_stall, ip && !(ackb && !win_d)); end
        if (ackb) begin
          if (win_d) last_d = rd; else last_i = rd;
          checks++;
          if ((win_d ? d_rdata : if_rdata) !== rd) begin errors++; $display("FAIL rand%0d_rdata: got %h want %h", t, win_d ? d_rdata : if_rdata, rd); end
        end
        if (ackb || errb) break;
      end
      @(negedge clk);
      mem_ack = 0;
      if (win_d) begin dp = 0; d_req = 0; end else begin ip = 0; if_req = 0; end
    end
    if_req = 0; d_req = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_write();
    test_contention();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_random(300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Arbitrates one shared single-port, variable-latency memory between the fetch stage (read-only) and the data/MEM stage (read/write).
- Sits between the pipeline stages and the memory. Latches the winning request, drives the memory handshake, and returns acknowledge and read data to the owner.
- Generates the fetch-stall signal consumed by the fetch stage.
- Aborts hung transactions after a programmable timeout.

Parameters:
- WIDTH, 32, data word width.
- ADDR_W, 30, word-address width (WIDTH-2).
- MAX_D_STREAK, 3, consecutive data grants allowed while fetch waits before fetch is forced through.
- TIMEOUT, 255, cycles in a busy state before abort.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request; held until if_ack or if_err.
- if_addr  in  ADDR_W  fetch word address.
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle.
- if_rdata  out  WIDTH  fetch read data.
- if_err  out  1  one-cycle pulse; fetch transaction timed out.
- if_stall  out  1  if_req & ~if_ack.
- d_req  in  1  data request; held until d_ack or d_err.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  WIDTH  write data.
- d_ack  out  1  one-cycle pulse; d_rdata valid on reads.
- d_rdata  out  WIDTH  data read data.
- d_err  out  1  one-cycle pulse; data transaction timed out.
- mem_req  out  1  memory request, held until mem_ack or abort.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, one-cycle pulse.

Behaviour:
- Reset (async, immediate, including mid-transaction):
  - State goes to IDLE; streak and timeout counters clear to 0.
  - mem_req, mem_we, if_ack, d_ack, if_err and d_err go to 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata go to 0.
  - Any in-flight memory transaction is abandoned; any late mem_ack after reset is ignored in IDLE.
- States: IDLE, BUSY_IF, BUSY_D.
- IDLE, on a rising edge:
  - Neither request: stay in IDLE.
  - d_req only: go to BUSY_D.
  - if_req only: go to BUSY_IF.
  - Both requests: go to BUSY_D, unless streak == MAX_D_STREAK, in which case go to BUSY_IF.
- On grant, the same edge registers mem_addr, mem_we and mem_wdata from the winner. Fetch grants force mem_we = 0.
- mem_req is registered and equals (state != IDLE). It asserts the cycle after the request is first seen.
- Streak counter:
  - Increments (saturating at MAX_D_STREAK) on a data grant while if_req is also high.
  - Clears on any fetch grant.
  - Unchanged on a data grant with no fetch pending.
- BUSY_x with mem_ack = 1:
  - The owner's ack pulses combinationally the same cycle.
  - The owner's rdata equals mem_rdata (registered copy also held until next ack).
  - Next state is IDLE.
  - Minimum request-to-ack latency is 1 cycle; minimum spacing between grants is 2 cycles.
- Timeout:
  - The counter clears on entry to a BUSY state and increments each busy cycle without mem_ack.
  - When it reaches TIMEOUT: owner's err pulses for one cycle, mem_req drops next edge, state returns to IDLE, no ack is issued.
  - mem_ack arriving in the same cycle as the timeout wins: ack is issued, no err.
- Requests changing during BUSY have no effect.
- A requester that deasserts req before its ack still has its transaction completed, and the ack/err pulse is still generated.
- mem_ack in IDLE is ignored.
- The non-owner's ack and err stay 0 throughout.
- if_stall is combinational and high during every cycle fetch waits, including while data owns the memory.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x10; memory acks 2 cycles after mem_req with 0xDEADBEEF -> mem_req rises cycle 1, mem_addr = 0x10, mem_we = 0, if_ack pulses cycle 3 with if_rdata = 0xDEADBEEF, if_stall high cycles 0–2.
- Data write: d_req = 1, d_we = 1, d_addr = 0x20, d_wdata = 0x12345678, immediate mem_ack -> mem_we = 1, mem_wdata = 0x12345678 at cycle 1, d_ack cycle 1, state IDLE cycle 2.
- Contention fairness: if_req held, d_req re-raised after every d_ack, MAX_D_STREAK = 3 -> grant order D, D, D, IF, D; streak returns to 0 after the IF grant.
- Timeout: TIMEOUT = 4, d_req with mem_ack never asserted -> d_err pulses once after 4 busy cycles, mem_req low next cycle, no d_ack; pending if_req is then granted.
- Ack/timeout collision: mem_ack on the exact timeout cycle -> ack issued, err stays 0.
- Reset mid-transaction: rst pulsed while in BUSY_D with mem_req = 1 -> mem_req, acks and errs go 0 immediately; a mem_ack 1 cycle after reset release produces no ack; the next if_req is granted normally.
